// File: rtl/stack_arbiter.sv
// Two-requester round-robin arbiter in front of a single push/pop stack port.
// Latency: gnt and stack strobe 1 cycle after req, done/err 3 cycles after; one transaction per 4 cycles.
module stack_arbiter #(
  parameter int DATA_WIDTH  = 4,
  parameter int STACK_DEPTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req0,
  input  logic                  req1,
  input  logic                  op0,
  input  logic                  op1,
  input  logic [DATA_WIDTH-1:0] wdata0,
  input  logic [DATA_WIDTH-1:0] wdata1,
  output logic                  gnt0,
  output logic                  gnt1,
  output logic                  done0,
  output logic                  done1,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  err,
  output logic                  stack_push,
  output logic                  stack_pop,
  output logic [DATA_WIDTH-1:0] stack_din,
  input  logic [DATA_WIDTH-1:0] stack_dout,
  input  logic                  stack_full,
  input  logic                  stack_empty
);

  // The depth belongs to the attached stack; only its sanity is checked here.
  if (STACK_DEPTH < 1) begin : g_bad_depth
    $error("STACK_DEPTH must be at least 1");
  end

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  state_t                r_state;
  logic                  r_last;
  logic                  r_id;
  logic                  r_op;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic                  r_reject;
  logic                  r_popped;
  logic [DATA_WIDTH-1:0] r_pop_dat;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic                  r_gnt0;
  logic                  r_gnt1;
  logic                  r_done0;
  logic                  r_done1;
  logic                  r_err;

  logic                  w_win;
  logic                  w_issue;
  logic                  w_reject;

  // On a tie the requester that was not granted last time wins.
  assign w_win    = (req0 && req1) ? ~r_last : req1;
  assign w_issue  = (r_state == ST_ISSUE) && !rst;
  assign w_reject = r_op ? stack_empty : stack_full;

  // Strobes look at the stack flags live in the ISSUE cycle.
  assign stack_push = w_issue && !r_op && !stack_full;
  assign stack_pop  = w_issue &&  r_op && !stack_empty;
  assign stack_din  = stack_push ? r_wdata : '0;

  assign gnt0  = r_gnt0  && !rst;
  assign gnt1  = r_gnt1  && !rst;
  assign done0 = r_done0 && !rst;
  assign done1 = r_done1 && !rst;
  assign err   = r_err   && !rst;
  assign rdata = r_rdata;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_last    <= 1'b1;
      r_id      <= 1'b0;
      r_op      <= 1'b0;
      r_wdata   <= '0;
      r_reject  <= 1'b0;
      r_popped  <= 1'b0;
      r_pop_dat <= '0;
      r_rdata   <= '0;
      r_gnt0    <= 1'b0;
      r_gnt1    <= 1'b0;
      r_done0   <= 1'b0;
      r_done1   <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_gnt0  <= 1'b0;
      r_gnt1  <= 1'b0;
      r_done0 <= 1'b0;
      r_done1 <= 1'b0;
      r_err   <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (req0 || req1) begin
            r_id    <= w_win;
            r_op    <= w_win ? op1 : op0;
            r_wdata <= w_win ? wdata1 : wdata0;
            r_last  <= w_win;
            r_gnt0  <= ~w_win;
            r_gnt1  <= w_win;
            r_state <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          r_reject <= w_reject;
          r_popped <= stack_pop;
          r_state  <= ST_WAIT;
        end
        ST_WAIT: begin
          // Stack read data is valid now; hold it until the response cycle.
          r_pop_dat <= stack_dout;
          r_done0   <= ~r_id;
          r_done1   <= r_id;
          r_err     <= r_reject;
          r_state   <= ST_RESP;
        end
        ST_RESP: begin
          if (r_popped) begin
            r_rdata <= r_pop_dat;
          end
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_stack_arbiter.sv
// Directed vector bench for stack_arbiter with a behavioural 4-entry stack.
module tb_stack_arbiter;
  localparam int DW = 4;
  localparam int SD = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req0 = 1'b0, req1 = 1'b0, op0 = 1'b0, op1 = 1'b0;
  logic [DW-1:0] wdata0 = '0, wdata1 = '0;
  logic          gnt0, gnt1, done0, done1, err, stack_push, stack_pop;
  logic [DW-1:0] rdata, stack_din;
  logic [DW-1:0] stack_dout = '0;
  logic          stack_full, stack_empty;

  stack_arbiter #(.DATA_WIDTH(DW), .STACK_DEPTH(16)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1), .op0(op0), .op1(op1),
    .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
    .rdata(rdata), .err(err),
    .stack_push(stack_push), .stack_pop(stack_pop), .stack_din(stack_din),
    .stack_dout(stack_dout), .stack_full(stack_full), .stack_empty(stack_empty)
  );

  always #5 clk = ~clk;

  // Behavioural stack: read data registered on the pop strobe and held.
  logic [DW-1:0] mem [SD];
  int            cnt = 0;
  assign stack_full  = (cnt == SD);
  assign stack_empty = (cnt == 0);
  always @(posedge clk) begin
    if (rst) begin
      cnt <= 0;
    end else if (stack_push && cnt < SD) begin
      mem[cnt] <= stack_din;
      cnt      <= cnt + 1;
    end else if (stack_pop && cnt > 0) begin
      stack_dout <= mem[cnt-1];
      cnt        <= cnt - 1;
    end
  end

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct packed {
    logic          rq;       // 0 -> requester 0, 1 -> requester 1
    logic          op;
    logic [DW-1:0] wd;
    logic          e_push;
    logic          e_pop;
    logic          e_err;
    logic [DW-1:0] e_rdata;
  } vec_t;

  vec_t          vecs [12];
  logic [DW-1:0] prev_rdata = '0;

  // Called one step after a rising edge with the DUT idle.
  task automatic run_vec(input vec_t v);
    if (v.rq) begin req1 = 1'b1; op1 = v.op; wdata1 = v.wd; end
    else      begin req0 = 1'b1; op0 = v.op; wdata0 = v.wd; end
    @(posedge clk); #1;
    chk("gnt0",  32'(gnt0), 32'(!v.rq));
    chk("gnt1",  32'(gnt1), 32'(v.rq));
    chk("push",  32'(stack_push), 32'(v.e_push));
    chk("pop",   32'(stack_pop),  32'(v.e_pop));
    chk("din",   32'(stack_din),  32'(v.e_push ? v.wd : 4'h0));
    req0 = 1'b0; req1 = 1'b0;
    @(posedge clk); #1;
    chk("wait_quiet", 32'({gnt0, gnt1, stack_push, stack_pop, done0, done1, err}), 32'h0);
    @(posedge clk); #1;
    chk("done0", 32'(done0), 32'(!v.rq));
    chk("done1", 32'(done1), 32'(v.rq));
    chk("err",   32'(err),   32'(v.e_err));
    chk("rdata_resp", 32'(rdata), 32'(prev_rdata));
    @(posedge clk); #1;
    chk("rdata_after", 32'(rdata), 32'(v.e_rdata));
    chk("done_clear",  32'({done0, done1, err}), 32'h0);
    prev_rdata = v.e_rdata;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    prev_rdata = '0;
  endtask

  initial begin
    //            rq    op    wd    push  pop   err   rdata
    vecs[0]  = '{1'b0, 1'b0, 4'hA, 1'b1, 1'b0, 1'b0, 4'h0};
    vecs[1]  = '{1'b1, 1'b0, 4'h5, 1'b1, 1'b0, 1'b0, 4'h0};
    vecs[2]  = '{1'b1, 1'b1, 4'h0, 1'b0, 1'b1, 1'b0, 4'h5};
    vecs[3]  = '{1'b0, 1'b1, 4'h0, 1'b0, 1'b1, 1'b0, 4'hA};
    vecs[4]  = '{1'b0, 1'b1, 4'h0, 1'b0, 1'b0, 1'b1, 4'hA};
    vecs[5]  = '{1'b1, 1'b0, 4'h1, 1'b1, 1'b0, 1'b0, 4'hA};
    vecs[6]  = '{1'b0, 1'b0, 4'h2, 1'b1, 1'b0, 1'b0, 4'hA};
    vecs[7]  = '{1'b1, 1'b0, 4'h3, 1'b1, 1'b0, 1'b0, 4'hA};
    vecs[8]  = '{1'b0, 1'b0, 4'h4, 1'b1, 1'b0, 1'b0, 4'hA};
    vecs[9]  = '{1'b1, 1'b0, 4'h7, 1'b0, 1'b0, 1'b1, 4'hA};
    vecs[10] = '{1'b0, 1'b1, 4'h0, 1'b0, 1'b1, 1'b0, 4'h4};
    vecs[11] = '{1'b1, 1'b1, 4'h0, 1'b0, 1'b1, 1'b0, 4'h3};

    // Outputs while reset is held.
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("rst_pulses", 32'({gnt0, gnt1, done0, done1, err, stack_push, stack_pop}), 32'h0);
    chk("rst_din",   32'(stack_din), 32'h0);
    chk("rst_rdata", 32'(rdata), 32'h0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("idle_quiet", 32'({gnt0, gnt1, done0, done1, err, stack_push, stack_pop}), 32'h0);

    for (int i = 0; i < 12; i++) run_vec(vecs[i]);

    // Tie from reset: grants 0,1,0,1 four cycles apart.
    do_reset();
    req0 = 1'b1; req1 = 1'b1; op0 = 1'b1; op1 = 1'b1;
    for (int c = 1; c <= 16; c++) begin
      @(posedge clk); #1;
      chk("tie_gnt0", 32'(gnt0), 32'(c % 8 == 1));
      chk("tie_gnt1", 32'(gnt1), 32'(c % 8 == 5));
    end
    req0 = 1'b0; req1 = 1'b0;
    @(posedge clk); #1;

    // Load rdata, then reset during WAIT of a pop granted to requester 0.
    do_reset();
    run_vec('{1'b0, 1'b0, 4'h6, 1'b1, 1'b0, 1'b0, 4'h0});
    run_vec('{1'b1, 1'b0, 4'h8, 1'b1, 1'b0, 1'b0, 4'h0});
    run_vec('{1'b1, 1'b1, 4'h0, 1'b0, 1'b1, 1'b0, 4'h8});
    req0 = 1'b1; op0 = 1'b1;
    @(posedge clk); #1;
    chk("mid_gnt0", 32'(gnt0), 32'h1);
    chk("mid_pop",  32'(stack_pop), 32'h1);
    req0 = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("mid_rst_quiet", 32'({gnt0, gnt1, done0, done1, err, stack_push, stack_pop}), 32'h0);
    chk("mid_rst_din", 32'(stack_din), 32'h0);
    @(posedge clk); #1;
    chk("mid_no_done", 32'({done0, done1, err, gnt0, gnt1}), 32'h0);
    chk("mid_rdata",   32'(rdata), 32'h0);
    rst = 1'b0;
    @(posedge clk); #1;
    req0 = 1'b1; req1 = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_tie_gnt0", 32'(gnt0), 32'h1);
    chk("post_rst_tie_gnt1", 32'(gnt1), 32'h0);
    req0 = 1'b0; req1 = 1'b0;
    for (int k = 0; k < 4; k++) begin @(posedge clk); #1; end

    // Random request stream: strobe exclusivity and one done per grant.
    begin
      int  n_g = 0, n_d = 0;
      logic last_id = 1'b0;
      for (int c = 0; c < 1000; c++) begin
        @(posedge clk); #1;
        chk("excl", 32'(stack_push && stack_pop), 32'h0);
        if (gnt0 || gnt1) begin n_g++; last_id = gnt1; end
        if (done0 || done1) begin
          n_d++;
          chk("done_id", 32'(done1), 32'(last_id));
        end
        req0 = 1'($urandom_range(1)); req1 = 1'($urandom_range(1));
        op0  = 1'($urandom_range(1)); op1  = 1'($urandom_range(1));
        wdata0 = 4'($urandom_range(15)); wdata1 = 4'($urandom_range(15));
      end
      req0 = 1'b0; req1 = 1'b0;
      for (int c = 0; c < 6; c++) begin
        @(posedge clk); #1;
        if (gnt0 || gnt1) n_g++;
        if (done0 || done1) n_d++;
      end
      chk("gnt_done_count", 32'(n_d), 32'(n_g));
      chk("random_active", 32'(n_g > 100), 32'h1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
